led_blink_driver: RTL and testbench

Output-side indicator driver for the front-panel LEDs, the counterpart of the push-button debouncer on the input side. It accepts a blink command over a valid/ready handshake and produces a prescaled on/off LED pattern repeated a programmed number of times. It then reports completion with a one-cycle pulse. Typical use: acknowledge button events, flag recording start/stop, or show error codes as blink counts.

---
 rtl/led_blink_driver.sv | 151 +++++++++++++++
 tb/tb_led_blink_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/led_blink_driver.sv
// Front-panel LED blink driver: accepts a blink command, plays count x (on/off)
// ticks of a prescaled clock, then pulses done. Abort returns to idle silently.
module led_blink_driver #(
  parameter int TICK_DIV = 1000,
  parameter int NB_W     = 4,
  parameter bit LED_INV  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [NB_W-1:0] cmd_count,
  input  logic [7:0]      cmd_on_ticks,
  input  logic [7:0]      cmd_off_ticks,
  input  logic            cmd_abort,
  output logic            led,
  output logic            busy,
  output logic            done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      tick_q, tick_d;
  logic [NB_W-1:0] rem_q, rem_d;
  logic            led_q, led_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  // Durations are stored as (ticks-1) so the compare never needs a subtractor.
  logic [7:0]      on_lim_q, off_lim_q;
  logic            tick;
  logic            accept;

  assign tick   = (presc_q == PRESC_MAX);
  assign accept = (state_q == S_IDLE) && cmd_valid;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = tick_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tick_d  = '0;
        if (cmd_valid) begin
          if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ON;
            rem_d   = cmd_count;
          end
        end
      end
      S_ON: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
          presc_d = '0;
          tick_d  = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (tick_q == on_lim_q) begin
              state_d = S_OFF;
              tick_d  = '0;
            end else begin
              tick_d = tick_q + 8'd1;
            end
          end
        end
      end
      S_OFF: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
          presc_d = '0;
          tick_d  = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (tick_q == off_lim_q) begin
              tick_d = '0;
              rem_d  = rem_q - NB_W'(1);
              if (rem_q == NB_W'(1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = S_ON;
              end
            end else begin
              tick_d = tick_q + 8'd1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        tick_d  = '0;
      end
    endcase
    // Outputs are decoded from the next state so they leave the flops glitch-free.
    led_d   = (state_d == S_ON) ^ LED_INV;
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tick_q  <= '0;
      rem_q   <= '0;
      led_q   <= LED_INV;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      on_lim_q  <= (cmd_on_ticks  == 8'd0) ? 8'd0 : cmd_on_ticks  - 8'd1;
      off_lim_q <= (cmd_off_ticks == 8'd0) ? 8'd0 : cmd_off_ticks - 8'd1;
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver: instance 0 (div 4), 1 (div 4, inverted)
// and 2 (div 1) share clock and reset.
module tb_led_blink_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd_valid = '0;
  logic [2:0] cmd_abort = '0;
  logic [2:0] cmd_ready;
  logic [2:0] led;
  logic [2:0] busy;
  logic [2:0] done;
  logic [3:0] cmd_count [3];
  logic [7:0] on_t      [3];
  logic [7:0] off_t     [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    led_blink_driver #(
      .TICK_DIV ((g == 2) ? 1 : 4),
      .NB_W     (4),
      .LED_INV  ((g == 1) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid[g]),
      .cmd_ready     (cmd_ready[g]),
      .cmd_count     (cmd_count[g]),
      .cmd_on_ticks  (on_t[g]),
      .cmd_off_ticks (off_t[g]),
      .cmd_abort     (cmd_abort[g]),
      .led           (led[g]),
      .busy          (busy[g]),
      .done          (done[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic [3:0] c, input logic [7:0] on, input logic [7:0] off);
    cmd_valid[i] = 1'b1;
    cmd_count[i] = c;
    on_t[i]      = on;
    off_t[i]     = off;
    step();
    cmd_valid[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_led;
    int   blinks;
    logic prev_led;
    for (int i = 0; i < 3; i++) begin
      cmd_count[i] = '0;
      on_t[i]      = '0;
      off_t[i]     = '0;
    end

    // reset values: {led,busy,done,ready}
    step();
    chk("reset1_i0", {led[0], busy[0], done[0], cmd_ready[0]}, 4'b0001);
    chk("reset1_i1", {led[1], busy[1], done[1], cmd_ready[1]}, 4'b1001);
    step();
    chk("reset2_i2", {led[2], busy[2], done[2], cmd_ready[2]}, 4'b0001);
    rst = 1'b0;
    step();

    // basic pattern on both polarities; instance 0 also holds a different command
    cmd_valid[0] = 1'b1; cmd_count[0] = 4'd2; on_t[0] = 8'd1; off_t[0] = 8'd2;
    cmd_valid[1] = 1'b1; cmd_count[1] = 4'd2; on_t[1] = 8'd1; off_t[1] = 8'd2;
    step();
    cmd_valid[1] = 1'b0;
    cmd_count[0] = 4'd5; on_t[0] = 8'd3; off_t[0] = 8'd3;
    for (int k = 0; k < 25; k++) begin
      exp_led = (k < 4) || (k >= 12 && k < 16);
      chk($sformatf("basic_i0_k%0d", k), {led[0], done[0], cmd_ready[0]},
          {exp_led, (k == 24), (k == 24)});
      chk($sformatf("basic_i1_k%0d", k), {led[1], done[1], busy[1]},
          {~exp_led, (k == 24), (k != 24)});
      step();
    end
    chk("b2b_start_i0", {led[0], busy[0], done[0]}, 3'b110);
    chk("after_done_i1", {led[1], busy[1], done[1]}, 3'b100);
    cmd_valid[0] = 1'b0;
    repeat (11) step();
    chk("b2b_on3_last", led[0], 1'b1);
    step();
    chk("b2b_on3_off", led[0], 1'b0);
    cmd_abort[0] = 1'b1;
    step();
    cmd_abort[0] = 1'b0;
    chk("abort_off", {led[0], busy[0], done[0], cmd_ready[0]}, 4'b0001);

    // abort mid-ON of the second of three blinks
    send(0, 4'd3, 8'd1, 8'd1);
    repeat (9) step();
    chk("blink2_on", led[0], 1'b1);
    cmd_abort[0] = 1'b1;
    step();
    cmd_abort[0] = 1'b0;
    chk("abort_on", {led[0], busy[0], done[0], cmd_ready[0]}, 4'b0001);
    repeat (12) step();
    chk("abort_no_done", {led[0], done[0]}, 2'b00);

    // abort together with a command in IDLE: command wins
    cmd_abort[0] = 1'b1;
    send(0, 4'd1, 8'd1, 8'd1);
    cmd_abort[0] = 1'b0;
    chk("abort_valid_acc", {led[0], busy[0], cmd_ready[0]}, 3'b110);
    repeat (7) step();
    chk("abort_valid_k7", {led[0], done[0]}, 2'b00);
    step();
    chk("abort_valid_done", {done[0], busy[0]}, 2'b10);

    // zero-count command
    send(0, 4'd0, 8'd5, 8'd5);
    chk("cnt0_done", {led[0], busy[0], done[0], cmd_ready[0]}, 4'b0011);
    step();
    chk("cnt0_drop", {led[0], done[0], cmd_ready[0]}, 3'b001);

    // zero on/off ticks treated as one
    send(0, 4'd1, 8'd0, 8'd0);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("zero_ticks_k%0d", k), {led[0], done[0]}, {(k < 4), (k == 8)});
      if (k < 8) step();
    end

    // reset mid-ON, then a clean pattern
    send(0, 4'd3, 8'd1, 8'd1);
    step();
    chk("pre_rst_on", led[0], 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_i0", {led[0], busy[0], done[0], cmd_ready[0]}, 4'b0001);
    chk("rst_mid_i1", {led[1], busy[1], done[1], cmd_ready[1]}, 4'b1001);
    send(0, 4'd1, 8'd1, 8'd1);
    repeat (8) step();
    chk("post_rst_done", {done[0], led[0]}, 2'b10);

    // limits at TICK_DIV=1
    send(2, 4'd15, 8'd255, 8'd255);
    blinks   = 1;
    prev_led = led[2];
    for (int k = 0; k < 7652; k++) begin
      exp_led = (k < 7650) && ((k % 510) < 255);
      chk($sformatf("limit_k%0d", k), {led[2], busy[2], done[2]},
          {exp_led, (k < 7650), (k == 7650)});
      if (led[2] && !prev_led) blinks++;
      prev_led = led[2];
      step();
    end
    chk("limit_blinks", blinks, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
